// File: rtl/burst_acc_pkg.sv
// Shared types and helpers for the burst accumulator: FSM states, mode encoding
// and a constant-evaluable clog2 used to size the accumulator and counter.
package burst_acc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam logic MODE_SUM  = 1'b0;
  localparam logic MODE_MEAN = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/burst_accumulator_if.sv
// Sample/control bundle between a sample source (master) and the burst
// accumulator (slave); dbg_state exposes the accumulator FSM for checkers.
interface burst_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 11
) ();

  // go_in is honoured only while idle; d_in is taken on every busy cycle with
  // d_valid_in=1 (no back-pressure); abort_in beats d_valid_in in the same
  // cycle; valid_out is a single-cycle strobe and data_out holds until the next one.
  logic                 go_in;
  logic                 mode_in;
  logic                 abort_in;
  logic                 d_valid_in;
  logic [DATA_W-1:0]    d_in;
  logic                 busy_out;
  logic                 valid_out;
  logic [OUT_W-1:0]     data_out;
  burst_acc_pkg::state_t dbg_state;

  modport master (
    output go_in, mode_in, abort_in, d_valid_in, d_in,
    input  busy_out, valid_out, data_out, dbg_state
  );

  modport slave (
    input  go_in, mode_in, abort_in, d_valid_in, d_in,
    output busy_out, valid_out, data_out, dbg_state
  );

endinterface

// File: rtl/burst_accumulator.sv
// Go-triggered burst accumulator: collects COUNT gapped samples after a go pulse
// and emits their sum or truncated mean with a one-cycle valid strobe.
module burst_accumulator
  import burst_acc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COUNT  = 4,
  parameter int OUT_W  = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  burst_accumulator_if.slave  bus
);

  localparam int CW = clog2(COUNT);
  localparam int SW = DATA_W + CW;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  if (COUNT < 2 || COUNT > 256 || (COUNT & (COUNT - 1)) != 0) begin : g_bad_count
    $error("burst_accumulator: COUNT must be a power of two in 2..256");
  end
  if (OUT_W < SW) begin : g_bad_out_w
    $error("burst_accumulator: OUT_W must be >= DATA_W + clog2(COUNT)");
  end

  state_t            state_q, state_d;
  logic [SW-1:0]     acc_q, acc_d, sum_next;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              valid_q, valid_d;
  logic [OUT_W-1:0]  data_q, data_d;

  // cnt counts accepted samples 0..COUNT-1, so the completing sample is the one seen at LAST.
  assign sum_next = acc_q + SW'(bus.d_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_SUM;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    valid_d = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.go_in) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
          mode_d  = bus.mode_in;
        end
      end
      ACC: begin
        if (bus.abort_in) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (bus.d_valid_in) begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b1;
            data_d  = (mode_q == MODE_MEAN) ? OUT_W'(sum_next >> CW) : OUT_W'(sum_next);
          end else begin
            acc_d = sum_next;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_out  = (state_q == ACC);
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_burst_accumulator.sv
// Bench for burst_accumulator: a default 8-bit/4-sample instance and a
// 12-bit/16-sample instance, driven directed then random against a burst model.
module tb_burst_accumulator;

  logic clk;
  logic rst_n;

  burst_accumulator_if #(.DATA_W(8),  .OUT_W(11)) bus0 ();
  burst_accumulator_if #(.DATA_W(12), .OUT_W(16)) bus1 ();

  burst_accumulator #(.DATA_W(8),  .COUNT(4),  .OUT_W(11)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  burst_accumulator #(.DATA_W(12), .COUNT(16), .OUT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard counters
  int total = 0;
  int bad   = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: per instance, is a burst open, its running total and sample count
  int     burst_len [2] = '{4, 16};
  bit     m_open    [2];
  longint m_total   [2];
  int     m_n       [2];
  bit     m_mean    [2];
  bit     exp_valid [2];
  longint exp_data  [2];
  longint exp_q[$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_open[k] = 1'b0; m_total[k] = 0; m_n[k] = 0; m_mean[k] = 1'b0;
      exp_valid[k] = 1'b0; exp_data[k] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step(input int k, input bit go, input bit mode, input bit abort,
                            input bit dv, input int d);
    exp_valid[k] = 1'b0;
    if (!m_open[k]) begin
      if (go) begin
        m_open[k] = 1'b1; m_total[k] = 0; m_n[k] = 0; m_mean[k] = mode;
      end
    end else if (abort) begin
      m_open[k] = 1'b0;
    end else if (dv) begin
      m_total[k] += d;
      m_n[k]++;
      if (m_n[k] == burst_len[k]) begin
        exp_data[k]  = m_mean[k] ? m_total[k] / burst_len[k] : m_total[k];
        exp_valid[k] = 1'b1;
        m_open[k]    = 1'b0;
        exp_q.push_back(exp_data[k]);
      end
    end
  endtask

  // driver: one cycle of stimulus on instance k, the other instance idles
  task automatic tick(input int k, input bit go, input bit mode, input bit abort,
                      input bit dv, input int d);
    @(negedge clk);
    bus0.go_in      = (k == 0) && go;
    bus0.mode_in    = (k == 0) && mode;
    bus0.abort_in   = (k == 0) && abort;
    bus0.d_valid_in = (k == 0) && dv;
    bus0.d_in       = 8'(d);
    bus1.go_in      = (k == 1) && go;
    bus1.mode_in    = (k == 1) && mode;
    bus1.abort_in   = (k == 1) && abort;
    bus1.d_valid_in = (k == 1) && dv;
    bus1.d_in       = 12'(d);
    model_step(0, (k == 0) && go, (k == 0) && mode, (k == 0) && abort, (k == 0) && dv, d & 255);
    model_step(1, (k == 1) && go, (k == 1) && mode, (k == 1) && abort, (k == 1) && dv, d & 4095);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic burst4(input bit mode, input int a, input int b, input int c, input int d);
    tick(0, 1, mode, 0, 0, 0);
    tick(0, 0, 0, 0, 1, a);
    tick(0, 0, 0, 0, 1, b);
    tick(0, 0, 0, 0, 1, c);
    tick(0, 0, 0, 0, 1, d);
  endtask

  // look at outputs just after the edge that captured the last sample
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // compare process: every cycle, both instances against the model
  always @(posedge clk) begin
    if (run_cmp) begin
      #1;
      chk("dut0_valid", bus0.valid_out, exp_valid[0]);
      chk("dut0_busy",  bus0.busy_out,  m_open[0]);
      chk("dut0_data",  bus0.data_out,  exp_data[0]);
      chk("dut1_valid", bus1.valid_out, exp_valid[1]);
      chk("dut1_busy",  bus1.busy_out,  m_open[1]);
      chk("dut1_data",  bus1.data_out,  exp_data[1]);
    end
  end

  initial begin
    int k, lim, maxd, got;
    bit aborted, dv, ab;

    rst_n = 1'b0;
    bus0.go_in = 0; bus0.mode_in = 0; bus0.abort_in = 0; bus0.d_valid_in = 0; bus0.d_in = '0;
    bus1.go_in = 0; bus1.mode_in = 0; bus1.abort_in = 0; bus1.d_valid_in = 0; bus1.d_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_busy",  bus0.busy_out,  0);
    chk("reset_valid", bus0.valid_out, 0);
    chk("reset_data",  bus0.data_out,  0);
    rst_n = 1'b1;
    run_cmp = 1'b1;

    // sum mode
    burst4(0, 10, 20, 30, 40);
    settle();
    chk("sum_data", bus0.data_out, 100);
    chk("sum_valid", bus0.valid_out, 1);
    chk("model_sum", exp_data[0], 100);
    idle(1);
    settle();
    chk("sum_valid_drop", bus0.valid_out, 0);
    chk("sum_busy_low", bus0.busy_out, 0);

    // mean mode truncates
    burst4(1, 10, 21, 30, 40);
    settle();
    chk("mean_data", bus0.data_out, 25);
    chk("model_mean", exp_data[0], 25);
    idle(2);

    // full-scale sum does not wrap
    burst4(0, 255, 255, 255, 255);
    settle();
    chk("max_sum", bus0.data_out, 1020);
    idle(1);

    // gapped input with an ignored mid-burst go
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 5);
    tick(0, 0, 0, 0, 0, 99);
    tick(0, 1, 1, 0, 0, 77);
    tick(0, 0, 0, 0, 1, 6);
    tick(0, 0, 0, 0, 0, 3);
    tick(0, 0, 0, 0, 1, 7);
    tick(0, 0, 0, 0, 1, 8);
    settle();
    chk("gap_data", bus0.data_out, 26);
    chk("gap_valid", bus0.valid_out, 1);
    idle(1);

    // abort beats a same-cycle sample
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 3);
    tick(0, 0, 0, 0, 1, 4);
    tick(0, 0, 0, 1, 1, 9);
    idle(3);
    settle();
    chk("abort_hold", bus0.data_out, 26);
    chk("abort_busy", bus0.busy_out, 0);
    burst4(0, 1, 2, 3, 4);
    settle();
    chk("after_abort", bus0.data_out, 10);

    // back-to-back: second go lands in the valid cycle
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 50);
    tick(0, 0, 0, 0, 1, 60);
    tick(0, 0, 0, 0, 1, 70);
    tick(0, 0, 0, 0, 1, 80);
    settle();
    chk("b2b_first", bus0.data_out, 260);
    chk("b2b_first_valid", bus0.valid_out, 1);
    burst4(0, 2, 4, 6, 8);
    settle();
    chk("b2b_second", bus0.data_out, 20);
    idle(1);

    // asynchronous reset mid-burst
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 11);
    tick(0, 0, 0, 0, 1, 12);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_busy",  bus0.busy_out,  0);
    chk("arst_valid", bus0.valid_out, 0);
    chk("arst_data",  bus0.data_out,  0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // wide instance: 16 x 4095
    tick(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) tick(1, 0, 0, 0, 1, 4095);
    settle();
    chk("wide_sum", bus1.data_out, 65520);
    tick(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) tick(1, 0, 0, 0, 1, 4095);
    settle();
    chk("wide_mean", bus1.data_out, 4095);
    idle(1);

    // random bursts on both instances
    for (int b = 0; b < 60; b++) begin
      k = $urandom_range(0, 1);
      lim = k ? 16 : 4;
      maxd = k ? 4095 : 255;
      got = 0;
      aborted = 1'b0;
      tick(k, 1, 1'($urandom_range(0, 1)), 0, 0, $urandom_range(0, maxd));
      while (got < lim && !aborted) begin
        dv = ($urandom_range(0, 3) != 0);
        ab = ($urandom_range(0, 40) == 0);
        tick(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab, dv,
             $urandom_range(0, maxd));
        if (ab) aborted = 1'b1;
        else if (dv) got++;
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);

    chk("completions_seen", (exp_q.size() > 0) ? 1 : 0, 1);
    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
